mem_arbiter: RTL

- Shares the single main-memory block port between the instruction cache and the data cache.
- Both caches issue 128-bit block refills (reads) or write-backs (writes) on a cache miss.
- Grants one requester at a time with round-robin fairness and registers the winning request.
- Drives the memory valid/ready handshake and returns read data plus a one-cycle done pulse to the granted cache.

---
 rtl/mem_arbiter.sv | 115 +++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one main-memory block port between the icache and dcache.
// One transaction in flight; winner's request is latched, issued with valid/ready, then acknowledged with a done pulse.
module mem_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int BLOCK_WIDTH = 128
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ic_req_i,
  input  logic                   ic_wen_i,
  input  logic [ADDR_WIDTH-1:0]  ic_addr_i,
  input  logic [BLOCK_WIDTH-1:0] ic_wdata_i,
  output logic [BLOCK_WIDTH-1:0] ic_rdata_o,
  output logic                   ic_done_o,
  input  logic                   dc_req_i,
  input  logic                   dc_wen_i,
  input  logic [ADDR_WIDTH-1:0]  dc_addr_i,
  input  logic [BLOCK_WIDTH-1:0] dc_wdata_i,
  output logic [BLOCK_WIDTH-1:0] dc_rdata_o,
  output logic                   dc_done_o,
  output logic                   mem_valid_o,
  output logic                   mem_wen_o,
  output logic [ADDR_WIDTH-1:0]  mem_addr_o,
  output logic [BLOCK_WIDTH-1:0] mem_wdata_o,
  input  logic                   mem_ready_i,
  input  logic [BLOCK_WIDTH-1:0] mem_rdata_i,
  output logic                   busy_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MEM  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic GRANT_IC = 1'b0;
  localparam logic GRANT_DC = 1'b1;

  logic [1:0]             state_reg;
  logic                   last_grant_reg;
  logic                   grant_reg;
  logic                   wen_reg;
  logic [ADDR_WIDTH-1:0]  addr_reg;
  logic [BLOCK_WIDTH-1:0] wdata_reg;
  logic [BLOCK_WIDTH-1:0] rdata_reg [2];

  logic                   pick_next;
  logic                   sel_wen;
  logic [ADDR_WIDTH-1:0]  sel_addr;
  logic [BLOCK_WIDTH-1:0] sel_wdata;

  // On a tie the requester that did not win last time goes first.
  always_comb begin
    pick_next = GRANT_IC;
    if (ic_req_i && dc_req_i) begin
      pick_next = (last_grant_reg == GRANT_IC) ? GRANT_DC : GRANT_IC;
    end else if (dc_req_i) begin
      pick_next = GRANT_DC;
    end
    sel_wen   = (pick_next == GRANT_DC) ? dc_wen_i   : ic_wen_i;
    sel_addr  = (pick_next == GRANT_DC) ? dc_addr_i  : ic_addr_i;
    sel_wdata = (pick_next == GRANT_DC) ? dc_wdata_i : ic_wdata_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      last_grant_reg <= GRANT_DC;
      grant_reg      <= GRANT_IC;
      wen_reg        <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (ic_req_i || dc_req_i) begin
            grant_reg      <= pick_next;
            last_grant_reg <= pick_next;
            wen_reg        <= sel_wen;
            addr_reg       <= {sel_addr[ADDR_WIDTH-1:4], 4'b0000};
            wdata_reg      <= sel_wdata;
            state_reg      <= MEM;
          end
        end
        MEM: begin
          if (mem_ready_i) begin
            state_reg <= RESP;
          end
        end
        RESP:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Per-requester refill data; only the granted cache's register loads, and only on a read.
  for (genvar gi = 0; gi < 2; gi++) begin : g_rdata
    always_ff @(posedge clk) begin
      if (rst) begin
        rdata_reg[gi] <= '0;
      end else if (state_reg == MEM && mem_ready_i && !wen_reg && grant_reg == gi[0]) begin
        rdata_reg[gi] <= mem_rdata_i;
      end
    end
  end

  assign ic_rdata_o  = rdata_reg[0];
  assign dc_rdata_o  = rdata_reg[1];
  assign ic_done_o   = (state_reg == RESP) && (grant_reg == GRANT_IC);
  assign dc_done_o   = (state_reg == RESP) && (grant_reg == GRANT_DC);
  assign mem_valid_o = (state_reg == MEM);
  assign mem_wen_o   = wen_reg;
  assign mem_addr_o  = addr_reg;
  assign mem_wdata_o = wdata_reg;
  assign busy_o      = (state_reg != IDLE);

endmodule
